// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared RV32I core types and encodings
package core_pkg;

  localparam int CORE_XLEN   = 32;
  localparam int CORE_REG_AW = 5;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_OR   = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;
  localparam logic [4:0] ALU_LUI  = 5'd10;

  localparam logic OPA_RS1 = 1'b0;
  localparam logic OPA_PC  = 1'b1;
  localparam logic OPB_RS2 = 1'b0;
  localparam logic OPB_IMM = 1'b1;

  typedef struct packed {
    logic                   valid;
    logic [CORE_XLEN-1:0]   pc;
    logic [CORE_XLEN-1:0]   rs1_data;
    logic [CORE_XLEN-1:0]   rs2_data;
    logic [CORE_XLEN-1:0]   imm;
    logic [CORE_REG_AW-1:0] rs1_addr;
    logic [CORE_REG_AW-1:0] rs2_addr;
    logic [CORE_REG_AW-1:0] rd_addr;
    logic [4:0]             alu_op;
    logic                   opa_sel;
    logic                   opb_sel;
    logic                   rd_wren;
    logic                   is_load;
  } id_ex_t;

  // A bubble is an all-zero register: invalid, no write, ALU_ADD, zero data.
  localparam id_ex_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/ex_operand_stage_if.sv
// rtl/ex_operand_stage_if.sv - decode, forwarding and ALU-side signals of the ID/EX stage
interface ex_operand_stage_if
  import core_pkg::*;
#(
  parameter int XLEN   = CORE_XLEN,
  parameter int REG_AW = CORE_REG_AW
);
  logic              i_valid;
  logic [XLEN-1:0]   i_pc;
  logic [XLEN-1:0]   i_rs1_data;
  logic [XLEN-1:0]   i_rs2_data;
  logic [XLEN-1:0]   i_imm;
  logic [REG_AW-1:0] i_rs1_addr;
  logic [REG_AW-1:0] i_rs2_addr;
  logic [REG_AW-1:0] i_rd_addr;
  logic [4:0]        i_alu_op;
  logic              i_opa_sel;
  logic              i_opb_sel;
  logic              i_rd_wren;
  logic              i_is_load;
  logic              i_stall;
  logic              i_flush;
  logic [REG_AW-1:0] i_mem_rd_addr;
  logic              i_mem_rd_wren;
  logic [XLEN-1:0]   i_mem_data;
  logic [REG_AW-1:0] i_wb_rd_addr;
  logic              i_wb_rd_wren;
  logic [XLEN-1:0]   i_wb_data;

  logic [XLEN-1:0]   o_operand_a;
  logic [XLEN-1:0]   o_operand_b;
  logic [4:0]        o_alu_op;
  logic [XLEN-1:0]   o_store_data;
  logic [XLEN-1:0]   o_pc;
  logic [REG_AW-1:0] o_rd_addr;
  logic              o_rd_wren;
  logic              o_is_load;
  logic              o_valid;
  logic              o_load_use_stall;

  modport master (
    output i_valid, i_pc, i_rs1_data, i_rs2_data, i_imm, i_rs1_addr, i_rs2_addr,
           i_rd_addr, i_alu_op, i_opa_sel, i_opb_sel, i_rd_wren, i_is_load,
           i_stall, i_flush, i_mem_rd_addr, i_mem_rd_wren, i_mem_data,
           i_wb_rd_addr, i_wb_rd_wren, i_wb_data,
    input  o_operand_a, o_operand_b, o_alu_op, o_store_data, o_pc, o_rd_addr,
           o_rd_wren, o_is_load, o_valid, o_load_use_stall
  );

  modport slave (
    input  i_valid, i_pc, i_rs1_data, i_rs2_data, i_imm, i_rs1_addr, i_rs2_addr,
           i_rd_addr, i_alu_op, i_opa_sel, i_opb_sel, i_rd_wren, i_is_load,
           i_stall, i_flush, i_mem_rd_addr, i_mem_rd_wren, i_mem_data,
           i_wb_rd_addr, i_wb_rd_wren, i_wb_data,
    output o_operand_a, o_operand_b, o_alu_op, o_store_data, o_pc, o_rd_addr,
           o_rd_wren, o_is_load, o_valid, o_load_use_stall
  );
endinterface

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - per-operand RAW bypass from EX/MEM and MEM/WB
module fwd_mux #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [XLEN-1:0]   rs_data,
  input  logic              mem_rd_wren,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic [XLEN-1:0]   mem_data,
  input  logic              wb_rd_wren,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic [XLEN-1:0]   wb_data,
  output logic [XLEN-1:0]   fwd_data
);
  logic rs_nonzero;
  logic mem_hit;
  logic wb_hit;

  // x0 is hardwired to zero, so a write targeting it must never be bypassed.
  assign rs_nonzero = (rs_addr != '0);
  assign mem_hit    = rs_nonzero & mem_rd_wren & (mem_rd_addr == rs_addr);
  assign wb_hit     = rs_nonzero & wb_rd_wren & (wb_rd_addr == rs_addr);

  always_comb begin
    fwd_data = rs_data;
    if (mem_hit) begin
      fwd_data = mem_data;
    end else if (wb_hit) begin
      fwd_data = wb_data;
    end
  end
endmodule

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX register with operand forwarding and load-use bubble insertion
module ex_operand_stage
  import core_pkg::*;
#(
  parameter int XLEN   = CORE_XLEN,
  parameter int REG_AW = CORE_REG_AW
) (
  input logic               i_clk,
  input logic               i_reset,
  ex_operand_stage_if.slave bus
);
  id_ex_t            q;
  id_ex_t            d_capture;
  logic              load_use;
  logic [XLEN-1:0]   fwd_rs1;
  logic [XLEN-1:0]   fwd_rs2;

  // Non-instructions are still captured but can never write rd or count as a load.
  always_comb begin
    d_capture          = ID_EX_BUBBLE;
    d_capture.valid    = bus.i_valid;
    d_capture.pc       = bus.i_pc;
    d_capture.rs1_data = bus.i_rs1_data;
    d_capture.rs2_data = bus.i_rs2_data;
    d_capture.imm      = bus.i_imm;
    d_capture.rs1_addr = bus.i_rs1_addr;
    d_capture.rs2_addr = bus.i_rs2_addr;
    d_capture.rd_addr  = bus.i_rd_addr;
    d_capture.alu_op   = bus.i_alu_op;
    d_capture.opa_sel  = bus.i_opa_sel;
    d_capture.opb_sel  = bus.i_opb_sel;
    d_capture.rd_wren  = bus.i_rd_wren & bus.i_valid;
    d_capture.is_load  = bus.i_is_load & bus.i_valid;
  end

  assign load_use = q.valid & q.is_load & q.rd_wren & (q.rd_addr != '0) & bus.i_valid &
                    ((bus.i_rs1_addr == q.rd_addr) | (bus.i_rs2_addr == q.rd_addr));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      q <= ID_EX_BUBBLE;
    end else if (bus.i_flush) begin
      q <= ID_EX_BUBBLE;
    end else if (!bus.i_stall) begin
      q <= load_use ? ID_EX_BUBBLE : d_capture;
    end
  end

  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
    .rs_addr     (q.rs1_addr),
    .rs_data     (q.rs1_data),
    .mem_rd_wren (bus.i_mem_rd_wren),
    .mem_rd_addr (bus.i_mem_rd_addr),
    .mem_data    (bus.i_mem_data),
    .wb_rd_wren  (bus.i_wb_rd_wren),
    .wb_rd_addr  (bus.i_wb_rd_addr),
    .wb_data     (bus.i_wb_data),
    .fwd_data    (fwd_rs1)
  );

  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
    .rs_addr     (q.rs2_addr),
    .rs_data     (q.rs2_data),
    .mem_rd_wren (bus.i_mem_rd_wren),
    .mem_rd_addr (bus.i_mem_rd_addr),
    .mem_data    (bus.i_mem_data),
    .wb_rd_wren  (bus.i_wb_rd_wren),
    .wb_rd_addr  (bus.i_wb_rd_addr),
    .wb_data     (bus.i_wb_data),
    .fwd_data    (fwd_rs2)
  );

  assign bus.o_operand_a      = (q.opa_sel == OPA_PC)  ? q.pc  : fwd_rs1;
  assign bus.o_operand_b      = (q.opb_sel == OPB_IMM) ? q.imm : fwd_rs2;
  assign bus.o_store_data     = fwd_rs2;
  assign bus.o_alu_op         = q.alu_op;
  assign bus.o_pc             = q.pc;
  assign bus.o_rd_addr        = q.rd_addr;
  assign bus.o_rd_wren        = q.rd_wren;
  assign bus.o_is_load        = q.is_load;
  assign bus.o_valid          = q.valid;
  assign bus.o_load_use_stall = load_use;
endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register of the pipelined RV32I core, plus EX-side operand forwarding and load-use hazard detection.
- Sits directly upstream of the ALU and drives its operand A, operand B and 5-bit op code every cycle.
- Registers decode outputs.
- Resolves RAW hazards from the EX/MEM and MEM/WB stages.
- Inserts a bubble on a load-use dependency.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register-address width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  decode slot holds a real instruction.
- i_pc  in  XLEN  decode PC.
- i_rs1_data, i_rs2_data  in  XLEN  regfile read data.
- i_imm  in  XLEN  decoded immediate.
- i_rs1_addr, i_rs2_addr, i_rd_addr  in  REG_AW  register indices.
- i_alu_op  in  5  ALU op code (ADD=0 … LUI=10).
- i_opa_sel  in  1  0=rs1, 1=pc.
- i_opb_sel  in  1  0=rs2, 1=imm.
- i_rd_wren  in  1  instruction writes rd.
- i_is_load  in  1  instruction is a load.
- i_stall  in  1  downstream hold; freeze all registers.
- i_flush  in  1  branch mispredict; squash this stage.
- i_mem_rd_addr  in  REG_AW  EX/MEM destination.
- i_mem_rd_wren  in  1  EX/MEM destination write enable.
- i_mem_data  in  XLEN  EX/MEM ALU result.
- i_wb_rd_addr  in  REG_AW  MEM/WB destination.
- i_wb_rd_wren  in  1  MEM/WB destination write enable.
- i_wb_data  in  XLEN  MEM/WB write-back value.
- o_operand_a, o_operand_b  out  XLEN  to ALU.
- o_alu_op  out  5  to ALU.
- o_store_data  out  XLEN  forwarded rs2 for stores.
- o_pc  out  XLEN  registered PC.
- o_rd_addr  out  REG_AW  registered destination.
- o_rd_wren  out  1  registered write enable.
- o_is_load  out  1  registered load flag.
- o_valid  out  1  registered valid.
- o_load_use_stall  out  1  combinational; tells fetch/decode to hold.

Behaviour:
- **Reset.** When i_reset=1 at a clock edge, all registered fields clear to 0, so o_valid=0, o_rd_wren=0, o_alu_op=0, o_pc=0. Combinational outputs follow from those zeroed fields.

**Register update priority per edge** (highest first):
1. reset.
2. i_flush: load a bubble. A bubble is valid=0, rd_wren=0, is_load=0, alu_op=0, with data fields zeroed.
3. i_stall: hold all fields.
4. o_load_use_stall: load a bubble.
5. Otherwise capture all i_* decode fields.

- Flush overrides stall and load-use. A flush during a stall still squashes.
- Latency: one cycle from decode inputs to registered outputs.
- When i_valid=0 the stage captures the fields anyway but forces rd_wren=0 and is_load=0.

**Load-use stall.** o_load_use_stall is asserted when all of the following hold:
- o_valid & o_is_load & o_rd_wren
- o_rd_addr != 0
- i_valid
- i_rs1_addr == o_rd_addr, or i_rs2_addr == o_rd_addr

The upstream stages hold while it is asserted. This stage takes exactly one bubble, after which the dependency is satisfied through forwarding from MEM/WB.

**Forwarding** (combinational, applied to the registered rs1/rs2 values). Done independently for rs1 and rs2:
- If mem_wren and mem_rd == rs and rs != 0, use i_mem_data.
- Else if wb_wren and wb_rd == rs and rs != 0, use i_wb_data.
- Else use the registered regfile data.
- EX/MEM wins over MEM/WB when both match. x0 is never forwarded.

**Operand and output selection.**
- o_operand_a = opa_sel ? o_pc : fwd_rs1.
- o_operand_b = opb_sel ? imm : fwd_rs2.
- o_store_data = fwd_rs2, regardless of opb_sel.
- Outputs present a bubble's values unchanged. Downstream stages gate their side effects with o_valid.

Decomposition:
- Package core_pkg holds:
  - ALU op localparams (ALU_ADD=5'd0 … ALU_LUI=5'd10).
  - OPA_RS1/OPA_PC and OPB_RS2/OPB_IMM encodings.
  - An id_ex_t packed struct for the registered fields.
- One natural sub-module: fwd_mux. It takes a register index, registered data and both forwarding sources, and returns the forwarded value. It is instantiated twice.

Test Plan:
1. **Reset and capture.** Reset for 2 cycles → all outputs 0. Then decode ADD x3,x1,x2 with rs1_data=5, rs2_data=7 → next cycle operand_a=5, operand_b=7, alu_op=0, rd=3, valid=1.
2. **EX/MEM forward.** Registered rs1=x3 with mem_rd=3, mem_wren=1, mem_data=0x100, and wb_rd=3, wb_data=0x200 → operand_a=0x100 (EX/MEM priority).
3. **x0 guard.** rs2=x0, mem_rd=0, mem_wren=1, mem_data=0xDEAD, opb_sel=0 → operand_b=registered rs2_data (0).
4. **Load-use.** Stage holds LW x5 (is_load=1); decode presents rs1=x5 → o_load_use_stall=1. Next cycle valid=0, then the dependent instruction enters and wb forward gives operand_a=wb_data.
5. **Stall vs flush.** i_stall=1 for 3 cycles → outputs frozen. i_stall=1 and i_flush=1 together → next cycle valid=0, rd_wren=0.
6. **PC/imm select.** AUIPC-style with opa_sel=1, opb_sel=1, pc=0x80, imm=0x1000 → operand_a=0x80, operand_b=0x1000. LUI (alu_op=10) → operand_b=imm.
